// File: rtl/spi_adc_pkg.sv
// spi_adc_pkg: shared states, frame geometry and MCP3002 command constants for spi2adc
package spi_adc_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, HOLD} state_t;
  localparam int FRAME_LEN = 16;
  localparam logic START_BIT = 1'b1;
  localparam logic SGL_BIT = 1'b1;
  localparam logic MSBF_BIT = 1'b1;
  localparam int DATA_FIRST = 6;
  localparam int DATA_LAST = 15;
  // Command bits after the start bit; START_BIT goes straight to adc_sdo on load
  function automatic logic [14:0] cmd_tail(input logic ch);
    return {SGL_BIT, ch, MSBF_BIT, 12'b0};
  endfunction
endpackage

// File: rtl/spi2adc_if.sv
// spi2adc_if: four-wire SPI link between the ADC master and the MCP3002
interface spi2adc_if;
  logic adc_cs;
  logic adc_sck;
  logic adc_sdo;
  logic adc_sdi;
  modport master(output adc_cs, adc_sck, adc_sdo, input adc_sdi);
  modport slave(input adc_cs, adc_sck, adc_sdo, output adc_sdi);
endinterface

// File: rtl/spi_phase_tick.sv
// spi_phase_tick: HALF_DIV-cycle phase divider; held at 0 by clr, tc marks the last cycle of a phase
module spi_phase_tick #(
  parameter int HALF_DIV = 25
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic clr,
  output logic tc,
  output logic first
);
  logic [7:0] cnt;
  // Each phase runs 0, HALF_DIV-1 .. 1, so it lasts HALF_DIV cycles and restarts at 0
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? 8'd0 : cnt == 8'd0 ? 8'(HALF_DIV - 1) : cnt - 8'd1;
  assign tc = !clr && cnt == 8'd1;
  assign first = !clr && cnt == 8'd0;
endmodule

// File: rtl/spi2adc.sv
// spi2adc: MCP3002 SPI read master, start pulse in, 10-bit sample with one-cycle valid out
// Define ADC_CONT_EN to free-run back-to-back conversions after the first accepted start.
module spi2adc
  import spi_adc_pkg::*;
#(
  parameter int HALF_DIV = 25
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             channel,
  spi2adc_if.master        spi,
  output logic [9:0]       data_out,
  output logic             data_valid,
  output logic             busy
);
  state_t state, nxt;
  logic tc, first, accept, done, reload, lo_entry, sample;
  logic [14:0] cmd_sr;
  logic [4:0] bit_cnt;
  logic [9:0] rx_sr;
  spi_phase_tick #(.HALF_DIV(HALF_DIV)) u_tick (
    .sysclk(sysclk), .rst_n(rst_n), .clr(state == IDLE), .tc(tc), .first(first)
  );
  assign accept = state == IDLE && start && !busy;
  assign done = state == HOLD && tc;
`ifdef ADC_CONT_EN
  assign reload = accept || done;
`else
  assign reload = accept;
`endif
  assign lo_entry = state == SCK_HI && tc;
  assign sample = state == SCK_HI && first && bit_cnt >= 5'(DATA_FIRST - 1) && bit_cnt <= 5'(DATA_LAST - 1);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? SETUP : IDLE;
      SETUP:   nxt = tc ? SCK_HI : SETUP;
      SCK_HI:  nxt = tc ? SCK_LO : SCK_HI;
      SCK_LO:  nxt = !tc ? SCK_LO : bit_cnt == 5'(FRAME_LEN) ? HOLD : SCK_HI;
      HOLD:    nxt = !tc ? HOLD : reload ? SETUP : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // busy stays up through the data_valid cycle so a start coinciding with it is dropped
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      spi.adc_cs <= 1'b1;
      spi.adc_sck <= 1'b0;
      spi.adc_sdo <= 1'b0;
      data_out <= '0;
      data_valid <= 1'b0;
      busy <= 1'b0;
      cmd_sr <= '0;
      bit_cnt <= '0;
      rx_sr <= '0;
    end else begin
      state <= nxt;
      spi.adc_cs <= !(nxt inside {SETUP, SCK_HI, SCK_LO});
      spi.adc_sck <= nxt == SCK_HI;
      busy <= nxt != IDLE || done;
      data_valid <= done;
      if (done) data_out <= rx_sr;
      if (reload) begin
        cmd_sr <= cmd_tail(channel);
        spi.adc_sdo <= START_BIT;
        bit_cnt <= '0;
      end else if (lo_entry) begin
        cmd_sr <= cmd_sr << 1;
        spi.adc_sdo <= cmd_sr[14];
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (sample) rx_sr <= {rx_sr[8:0], spi.adc_sdi};
    end
endmodule

// File: tb/tb_spi2adc.sv
// tb_spi2adc: directed vectors against two spi2adc instances (HALF_DIV 25 and 2) with an MCP3002 model
module tb_spi2adc;
  typedef struct {
    int         sel;
    logic       ch;
    logic [9:0] code;
    logic [3:0] cmd;
    int         lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_v[2];
  logic chan[2];
  logic dv[2];
  logic busy[2];
  logic [9:0] dout[2];
  logic [9:0] code[2];
  logic [3:0] cmd[2];
  int rises[2];
  int falls[2];
  int dv_cnt[2];
  int errors = 0;
  int checks = 0;
  vec_t v[4];
  always #5 clk = ~clk;
  spi2adc_if ifs[2] ();
  spi2adc #(.HALF_DIV(25)) dut (
    .sysclk(clk), .rst_n(rst_n), .start(start_v[0]), .channel(chan[0]), .spi(ifs[0]),
    .data_out(dout[0]), .data_valid(dv[0]), .busy(busy[0])
  );
  spi2adc #(.HALF_DIV(2)) dut2 (
    .sysclk(clk), .rst_n(rst_n), .start(start_v[1]), .channel(chan[1]), .spi(ifs[1]),
    .data_out(dout[1]), .data_valid(dv[1]), .busy(busy[1])
  );
  // ADC model drives DOUT after falling SCK; monitor counts rising SCK, command bits and valid pulses
  for (genvar g = 0; g < 2; g++) begin : g_adc
    logic cs_p = 1'b1;
    logic sck_p = 1'b0;
    initial begin
      falls[g] = 0;
      rises[g] = 0;
      cmd[g] = '0;
      dv_cnt[g] = 0;
      ifs[g].adc_sdi = 1'b0;
    end
    always @(negedge clk) begin
      if (cs_p && !ifs[g].adc_cs) begin
        falls[g] = 0;
        rises[g] = 0;
        cmd[g] = '0;
        ifs[g].adc_sdi = 1'b0;
      end
      if (!ifs[g].adc_cs && ifs[g].adc_sck && !sck_p) begin
        rises[g]++;
        if (rises[g] <= 4) cmd[g] = {cmd[g][2:0], ifs[g].adc_sdo};
      end
      if (sck_p && !ifs[g].adc_sck) begin
        falls[g]++;
        if (falls[g] >= 5 && falls[g] <= 14) ifs[g].adc_sdi = code[g][14-falls[g]];
        else ifs[g].adc_sdi = 1'b0;
      end
      if (dv[g]) dv_cnt[g]++;
      cs_p = ifs[g].adc_cs;
      sck_p = ifs[g].adc_sck;
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic run(input int s, input logic ch, input logic [9:0] c, output int lat);
    code[s] = c;
    chan[s] = ch;
    @(negedge clk) start_v[s] = 1'b1;
    @(posedge clk);
    #1 start_v[s] = 1'b0;
    lat = 1;
    while (!dv[s] && lat < 3000) begin
      @(posedge clk);
      #1 lat++;
    end
    repeat (3) @(negedge clk);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, base, n;
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    chan[0] = 1'b0; chan[1] = 1'b0;
    code[0] = '0; code[1] = '0;
    v[0] = '{0, 1'b0, 10'h2A5, 4'b1101, 851};
    v[1] = '{0, 1'b1, 10'h3FF, 4'b1111, 851};
    v[2] = '{0, 1'b1, 10'h000, 4'b1111, 851};
    v[3] = '{1, 1'b0, 10'h155, 4'b1101, 69};
    repeat (3) @(negedge clk);
    chk("rst_cs", ifs[0].adc_cs, 1);
    chk("rst_sck", ifs[0].adc_sck, 0);
    chk("rst_sdo", ifs[0].adc_sdo, 0);
    chk("rst_data", dout[0], 0);
    chk("rst_valid", dv[0], 0);
    chk("rst_busy", busy[0], 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // Abort a frame during SCK cycle 8 with the asynchronous reset
    code[0] = 10'h2A5;
    base = dv_cnt[0];
    start_v[0] = 1'b1;
    @(negedge clk) start_v[0] = 1'b0;
    n = 0;
    while (rises[0] < 8 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach8", rises[0], 8);
    repeat (5) @(negedge clk);
    chk("abort_sck_before", ifs[0].adc_sck, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_cs", ifs[0].adc_cs, 1);
    chk("abort_sck", ifs[0].adc_sck, 0);
    chk("abort_busy", busy[0], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_data", dout[0], 0);
    chk("abort_no_valid", dv_cnt[0] - base, 0);
`ifdef ADC_CONT_EN
    code[0] = 10'h001;
    @(negedge clk) start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    lat = 1;
    while (!dv[0] && lat < 3000) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("cont_lat", lat, 851);
    chk("cont_data1", dout[0], 10'h001);
    chk("cont_busy1", busy[0], 1);
    for (int k = 2; k <= 3; k++) begin
      code[0] = 10'(k);
      n = 0;
      do begin
        @(posedge clk);
        #1 n++;
        start_v[0] = n == 100;
        if (n == 400) chk($sformatf("cont_busy_mid%0d", k), busy[0], 1);
      end while (!dv[0] && n < 3000);
      start_v[0] = 1'b0;
      chk($sformatf("cont_period%0d", k), n, 850);
      chk($sformatf("cont_data%0d", k), dout[0], k);
      chk($sformatf("cont_busy%0d", k), busy[0], 1);
    end
    repeat (3) @(negedge clk);
    chk("cont_pulses", dv_cnt[0] - base, 3);
`else
    for (int i = 0; i < 4; i++) begin
      base = dv_cnt[v[i].sel];
      run(v[i].sel, v[i].ch, v[i].code, lat);
      chk($sformatf("v%0d_latency", i), lat, v[i].lat);
      chk($sformatf("v%0d_data", i), dout[v[i].sel], v[i].code);
      chk($sformatf("v%0d_cmd", i), cmd[v[i].sel], v[i].cmd);
      chk($sformatf("v%0d_sck_rises", i), rises[v[i].sel], 16);
      chk($sformatf("v%0d_valid_count", i), dv_cnt[v[i].sel] - base, 1);
      chk($sformatf("v%0d_busy_idle", i), busy[v[i].sel], 0);
      chk($sformatf("v%0d_cs_idle", i), ifs[0].adc_cs & ifs[1].adc_cs, 1);
    end
    // Start while busy, start on the valid cycle, then start on the following cycle
    code[0] = 10'h1C3;
    chan[0] = 1'b0;
    base = dv_cnt[0];
    @(negedge clk) start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    n = 1;
    while (!dv[0] && n < 3000) begin
      @(posedge clk);
      #1 n++;
      start_v[0] = n == 100;
    end
    start_v[0] = 1'b1;
    chk("busy_start_lat", n, 851);
    chk("busy_start_data", dout[0], 10'h1C3);
    chk("busy_at_valid", busy[0], 1);
    @(posedge clk);
    #1;
    chk("valid_cycle_start_dropped", busy[0], 0);
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    chk("next_cycle_start_accepted", busy[0], 1);
    chk("single_frame_valid", dv_cnt[0] - base, 1);
    code[0] = 10'h0F0;
    n = 1;
    while (!dv[0] && n < 3000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("restart_lat", n, 851);
    chk("restart_data", dout[0], 10'h0F0);
    repeat (3) @(negedge clk);
    chk("restart_valid_count", dv_cnt[0] - base, 2);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
